// File: rtl/subword_store_unit_if.sv
// Store-unit bus bundle: datapath request side plus word-addressed memory port.
// The unit takes the slave view; the store stage and memory sit on the master side.
interface subword_store_unit_if;
  logic        Start;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [1:0]  Size;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
  logic        Busy;
  logic        Done;
  logic        Err;

  modport slave (
    input  Start, Addr, WriteData, Size, MemRData, MemReady,
    output MemAddr, MemRead, MemWrite, MemWData, Busy, Done, Err
  );

  modport master (
    output Start, Addr, WriteData, Size, MemRData, MemReady,
    input  MemAddr, MemRead, MemWrite, MemWData, Busy, Done, Err
  );
endinterface

// File: rtl/subword_store_unit.sv
// Byte/halfword/word store into word-addressed memory; sub-word stores use
// read-modify-write, and Busy stalls the datapath until the Done pulse.
module subword_store_unit (
  input  logic                  Clk,
  input  logic                  Rst,
  subword_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [1:0]  size_reg;
  logic [31:0] merge_reg;
  logic        err_reg;

  logic        req_err;
  logic [3:0]  lane_sel;
  logic [31:0] merged;

  assign req_err = (bus.Size == 2'b11) ||
                   ((bus.Size == 2'b01) && bus.Addr[0]) ||
                   ((bus.Size == 2'b00) && (bus.Addr[1:0] != 2'b00));

  // Byte lanes that take store data; all other lanes keep the memory word.
  always_comb begin
    lane_sel = 4'b0000;
    case (size_reg)
      2'b10:   lane_sel[addr_reg[1:0]] = 1'b1;
      2'b01:   lane_sel = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_src;
      always_comb begin
        case (size_reg)
          2'b10:   lane_src = data_reg[7:0];
          2'b01:   lane_src = data_reg[8*(gi%2) +: 8];
          default: lane_src = data_reg[8*gi +: 8];
        endcase
      end
      assign merged[8*gi +: 8] = lane_sel[gi] ? lane_src : bus.MemRData[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
      addr_reg  <= 32'h0;
      data_reg  <= 32'h0;
      size_reg  <= 2'b00;
      merge_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (bus.Start) begin
          addr_reg  <= bus.Addr;
          data_reg  <= bus.WriteData;
          size_reg  <= bus.Size;
          err_reg   <= req_err;
          // Word stores skip READ, so the write word is ready now.
          merge_reg <= bus.WriteData;
        end
        READ: if (bus.MemReady) merge_reg <= merged;
        default: ;
      endcase
    end
  end

  // Outputs decode from state and latched registers only.
  always_comb begin
    state_next   = state_reg;
    bus.MemAddr  = 32'h0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemWData = 32'h0;
    bus.Busy     = 1'b1;
    bus.Done     = 1'b0;
    bus.Err      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.Busy = 1'b0;
        if (bus.Start) begin
          if (req_err)                 state_next = DONE;
          else if (bus.Size == 2'b00)  state_next = WRITE;
          else                         state_next = READ;
        end
      end
      READ: begin
        bus.MemAddr = {addr_reg[31:2], 2'b00};
        bus.MemRead = 1'b1;
        if (bus.MemReady) state_next = WRITE;
      end
      WRITE: begin
        bus.MemAddr  = {addr_reg[31:2], 2'b00};
        bus.MemWrite = 1'b1;
        bus.MemWData = merge_reg;
        if (bus.MemReady) state_next = DONE;
      end
      DONE: begin
        bus.Done   = 1'b1;
        bus.Err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_subword_store_unit.sv
// Directed bench for subword_store_unit: a memory responder with wait states,
// a transaction-level store model, and a per-cycle compare process.
module tb_subword_store_unit;

  logic Clk = 1'b0;
  logic Rst;

  subword_store_unit_if bus ();

  subword_store_unit dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  bit [31:0] mem [bit [31:0]];
  int read_waits  = 0;
  int write_waits = 0;
  int wait_cnt    = 0;

  // Expected behaviour of the transaction in flight.
  bit        txn_active = 1'b0;
  int        txn_edge;
  int        txn_lat;
  bit [31:0] txn_addr;
  bit [31:0] txn_exp_word;
  bit        txn_err;
  bit        txn_word;
  bit        seen_read;
  bit        seen_write;
  bit [31:0] last_wdata;
  int        done_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input bit [31:0] a, input bit [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
  endfunction

  // Little-endian lane replacement expressed as a shifted mask.
  function automatic bit [31:0] model_word(input bit [31:0] old, input bit [31:0] a,
                                           input bit [1:0] sz, input bit [31:0] wd);
    int        sh;
    bit [31:0] mask;
    sh = 8 * int'(a[1:0]);
    case (sz)
      2'b10:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Memory responder: answers each request after a configurable number of wait cycles.
  always @(negedge Clk) begin
    if (bus.MemRead || bus.MemWrite) begin
      if (wait_cnt < (bus.MemRead ? read_waits : write_waits)) begin
        bus.MemReady = 1'b0;
        bus.MemRData = $urandom;
        wait_cnt++;
      end else begin
        bus.MemReady = 1'b1;
        wait_cnt     = 0;
        if (bus.MemRead)
          bus.MemRData = mem.exists(bus.MemAddr) ? mem[bus.MemAddr] : 32'h0;
        else
          mem[bus.MemAddr] = bus.MemWData;
      end
    end else begin
      bus.MemReady = 1'($urandom_range(0, 1));
      bus.MemRData = $urandom;
      wait_cnt     = 0;
    end
  end

  // Compare process: samples 2 time units after each rising edge.
  always @(posedge Clk) begin
    cycle++;
    #2;
    if (Rst === 1'b1) begin
      check("rd_wr_exclusive", {31'b0, bus.MemRead & bus.MemWrite}, 32'h0);
      if (txn_active) begin
        check("busy", {31'b0, bus.Busy},
              {31'b0, (cycle >= txn_edge) && (cycle <= txn_edge + txn_lat - 1)});
        check("done", {31'b0, bus.Done}, {31'b0, cycle == txn_edge + txn_lat - 1});
        if (bus.MemRead) begin
          seen_read = 1'b1;
          check("rd_addr", bus.MemAddr, txn_addr);
        end
        if (bus.MemWrite) begin
          seen_write = 1'b1;
          last_wdata = bus.MemWData;
          check("wr_addr", bus.MemAddr, txn_addr);
          check("wr_data", bus.MemWData, txn_exp_word);
        end
        if (!bus.MemRead && !bus.MemWrite)
          check("addr_quiet", bus.MemAddr, 32'h0);
        if (bus.Done) begin
          check("err", {31'b0, bus.Err}, {31'b0, txn_err});
          check("read_seen", {31'b0, seen_read}, {31'b0, !txn_err && !txn_word});
          check("write_seen", {31'b0, seen_write}, {31'b0, !txn_err});
          done_cycle = cycle - txn_edge + 1;
          txn_active = 1'b0;
        end
      end else begin
        check("idle_busy", {31'b0, bus.Busy}, 32'h0);
        check("idle_done", {31'b0, bus.Done}, 32'h0);
        check("idle_req", {30'b0, bus.MemRead, bus.MemWrite}, 32'h0);
        check("idle_addr", bus.MemAddr, 32'h0);
      end
    end
  end

  task automatic issue(input bit [31:0] a, input bit [1:0] sz, input bit [31:0] wd);
    bit [31:0] wa;
    bit [31:0] old;
    int        n;
    @(negedge Clk);
    n = 0;
    while (bus.Busy && n < 20) begin
      @(negedge Clk);
      n++;
    end
    wa  = {a[31:2], 2'b00};
    old = mem.exists(wa) ? mem[wa] : 32'h0;
    txn_addr     = wa;
    txn_err      = model_err(a, sz);
    txn_word     = (sz == 2'b00);
    txn_exp_word = model_word(old, a, sz, wd);
    txn_lat      = txn_err ? 1 : (txn_word ? 2 + write_waits : 3 + read_waits + write_waits);
    txn_edge     = cycle + 1;
    seen_read    = 1'b0;
    seen_write   = 1'b0;
    txn_active   = 1'b1;
    bus.Start     = 1'b1;
    bus.Addr      = a;
    bus.Size      = sz;
    bus.WriteData = wd;
    @(negedge Clk);
    bus.Start     = 1'b0;
    bus.Addr      = $urandom;
    bus.WriteData = $urandom;
    bus.Size      = 2'($urandom);
  endtask

  task automatic finish_txn(input string name, input int exp_cyc,
                            input bit [31:0] exp_w, input bit chk_w);
    int n;
    n = 0;
    while (txn_active && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (txn_active) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no Done within 60 cycles, expected Done at cycle %0d", name, exp_cyc);
      txn_active = 1'b0;
    end else begin
      check({name, "_latency"}, done_cycle, exp_cyc);
      if (chk_w) check({name, "_word"}, last_wdata, exp_w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0; bus.Addr = 32'h0; bus.WriteData = 32'h0; bus.Size = 2'b00;
    bus.MemReady = 1'b0; bus.MemRData = 32'h0;
    Rst = 1'b0;
    #1;
    check("rst_memaddr", bus.MemAddr, 32'h0);
    check("rst_memread", {31'b0, bus.MemRead}, 32'h0);
    check("rst_memwrite", {31'b0, bus.MemWrite}, 32'h0);
    check("rst_memwdata", bus.MemWData, 32'h0);
    check("rst_busy", {31'b0, bus.Busy}, 32'h0);
    check("rst_done", {31'b0, bus.Done}, 32'h0);
    check("rst_err", {31'b0, bus.Err}, 32'h0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;

    mem[32'h100] = 32'h1122_3344;
    issue(32'h102, 2'b10, 32'hFFFF_FFAB);
    finish_txn("byte", 3, 32'h11AB_3344, 1'b1);

    mem[32'h200] = 32'hDEAD_BEEF;
    issue(32'h200, 2'b01, 32'h0000_1234);
    finish_txn("half_lo", 3, 32'hDEAD_1234, 1'b1);
    mem[32'h200] = 32'hDEAD_BEEF;
    issue(32'h202, 2'b01, 32'h0000_1234);
    finish_txn("half_hi", 3, 32'h1234_BEEF, 1'b1);

    issue(32'h300, 2'b00, 32'hCAFE_F00D);
    finish_txn("word", 2, 32'hCAFE_F00D, 1'b1);

    issue(32'h101, 2'b01, 32'h0000_5555);
    finish_txn("err_half", 1, 32'h0, 1'b0);
    issue(32'h302, 2'b00, 32'h1234_5678);
    finish_txn("err_word", 1, 32'h0, 1'b0);
    issue(32'h400, 2'b11, 32'h1234_5678);
    finish_txn("err_size", 1, 32'h0, 1'b0);

    mem[32'h600] = 32'hA5A5_A5A5;
    issue(32'h600, 2'b10, 32'h1234_5678);
    finish_txn("byte_l0", 3, 32'hA5A5_A578, 1'b1);
    issue(32'h601, 2'b10, 32'hFFFF_009A);
    finish_txn("byte_l1", 3, 32'hA5A5_9A78, 1'b1);
    issue(32'h603, 2'b10, 32'h0000_00BC);
    finish_txn("byte_l3", 3, 32'hBCA5_9A78, 1'b1);

    // Read wait states with a competing Start that must be ignored.
    read_waits = 3;
    issue(32'h101, 2'b10, 32'hFFFF_FF55);
    bus.Start = 1'b1; bus.Addr = 32'h700; bus.Size = 2'b00; bus.WriteData = 32'h0BAD_0BAD;
    @(negedge Clk);
    bus.Start = 1'b0;
    finish_txn("wait_rd", 6, 32'h11AB_5544, 1'b1);
    read_waits = 0;

    write_waits = 2;
    issue(32'h602, 2'b01, 32'hFFFF_C0DE);
    finish_txn("wait_wr", 5, 32'hC0DE_9A78, 1'b1);

    // Abort in the middle of a stalled write.
    write_waits = 5;
    issue(32'h800, 2'b00, 32'h1111_2222);
    Rst = 1'b0;
    txn_active = 1'b0;
    #1;
    check("abort_memwrite", {31'b0, bus.MemWrite}, 32'h0);
    check("abort_busy", {31'b0, bus.Busy}, 32'h0);
    check("abort_done", {31'b0, bus.Done}, 32'h0);
    check("abort_memaddr", bus.MemAddr, 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    write_waits = 0;
    check("abort_no_write", {31'b0, mem.exists(32'h800)}, 32'h0);
    issue(32'h800, 2'b00, 32'h3333_4444);
    finish_txn("post_abort", 2, 32'h3333_4444, 1'b1);

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subword_store_unit.md
# subword_store_unit

Store-path counterpart to the datapath's load-side extension logic: narrows a 32-bit register value to a byte or halfword and writes it into word-addressed data memory. Byte and halfword stores use a read-modify-write sequence; word stores write directly. The unit sits between the datapath's store stage and the data memory port, and stalls the datapath through `Busy` until `Done`.

## Interface

Parameters:
- none; all widths are fixed (32-bit data, 32-bit byte address).

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request strobe; sampled only in IDLE.
- `Addr`  in  32  byte address of the store.
- `WriteData`  in  32  register value; only the low bits required by `Size` are used.
- `Size`  in  2  00 = word, 01 = halfword, 10 = byte, 11 = illegal.
- `MemAddr`  out  32  word-aligned address, `{Addr[31:2],2'b00}`.
- `MemRead`  out  1  read request.
- `MemWrite`  out  1  write request.
- `MemWData`  out  32  merged write word.
- `MemRData`  in  32  read data; valid when `MemReady`=1 during READ.
- `MemReady`  in  1  memory completion for the current read or write.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  valid with `Done`: 1 = misaligned or illegal request, no memory access.

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE with `Start`=1: latch `Addr`, `WriteData` and `Size` into internal registers. Inputs are don't-care after this edge.
  - Error condition: `Size`=11, or halfword with `Addr[0]`=1, or word with `Addr[1:0]`≠00. On error, set the error flag and go to DONE.
  - Word request goes to WRITE.
  - Byte or halfword request goes to READ.
- READ: `MemRead`=1. Stay in READ while `MemReady`=0. On `MemReady`=1, capture `MemRData` into the merge register and go to WRITE.
- WRITE: `MemWrite`=1 and `MemWData`=merged word. Stay in WRITE while `MemReady`=0. On `MemReady`=1, go to DONE.
- DONE: `Done`=1 and `Err`=error flag for exactly one cycle, then go to IDLE. The error flag clears on the next accepted `Start`.
- Merge rules (little-endian lanes; k = `Addr[1:0]`):
  - Byte: bits [8k+7:8k] are replaced by `WriteData[7:0]`. All other bits come from `MemRData`.
  - Halfword: offset 0 replaces [15:0] and offset 2 replaces [31:16] with `WriteData[15:0]`. The other half comes from `MemRData`.
  - Word: `MemWData` = `WriteData`, with no read.
- `MemAddr` is held constant from the cycle after `Start` is accepted through WRITE. It is 0 in IDLE and DONE.
- `MemRead` and `MemWrite` are never high in the same cycle.
- `MemReady` is ignored in IDLE and DONE.
- `Start` is ignored while `Busy`=1; no queuing.

## Timing

- Reset (`Rst`=0, asynchronous) forces state to IDLE. It also clears the latched request, the merge register and the error flag.
  - Reset values: `MemAddr`=0, `MemRead`=0, `MemWrite`=0, `MemWData`=0, `Busy`=0, `Done`=0, `Err`=0.
- Reset mid-READ or mid-WRITE aborts immediately. No `Done` is produced, and the memory request drops in the same cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `Start` to memory outputs.
- Latency from the `Start` edge to `Done` high, with `MemReady` returned in the first request cycle:
  - Byte/halfword: READ (1) + WRITE (1) + DONE → `Done` in cycle 3.
  - Word: WRITE (1) + DONE → `Done` in cycle 2.
  - Error: DONE → `Done` in cycle 1.
- Each memory wait cycle adds one cycle.
- `Start` may be reasserted in the `Done` cycle; it is accepted on the following IDLE cycle.

## Test plan

- Byte store: memory word 0x11223344 at 0x100. `Start`, `Addr`=0x102, `Size`=10, `WriteData`=0xFFFFFFAB → `MemRead` at 0x100, then `MemWData`=0x11AB3344, `Done`=1, `Err`=0, at cycle 3.
- Halfword store: word 0xDEADBEEF. `Addr`=0x200, `Size`=01, `WriteData`=0x00001234 → `MemWData`=0xDEAD1234. Repeat at `Addr`=0x202 → 0x1234BEEF.
- Word store: `Addr`=0x300, `WriteData`=0xCAFEF00D → no `MemRead`, `MemWrite` with 0xCAFEF00D, `Done` at cycle 2.
- Misaligned requests: halfword at 0x101, word at 0x302, and `Size`=11 → `Done`=1 with `Err`=1 at cycle 1; `MemRead`=`MemWrite`=0 throughout.
- Wait states and ignored `Start`: hold `MemReady`=0 for 3 cycles in READ while pulsing `Start` with a different `Addr` → request outputs stay stable, the second `Start` is ignored, and `Done` arrives at cycle 6.
- Reset abort: assert `Rst`=0 during WRITE → `MemWrite`=0 and `Busy`=0 immediately; no `Done`; the next `Start` completes normally.
